// File: rtl/aes_round_pipe.sv
// One AES-128 encryption round (SubBytes, ShiftRows, MixColumns, AddRoundKey) split
// into 1..3 elastic register stages; round key, last flag and tag travel with each block.
module aes_round_pipe #(
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_data,
   input  logic [127:0]     in_rkey,
   input  logic             in_last,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic [TAG_W-1:0] out_tag
);

   // Forward S-box, entry 0x00 in the top byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
      return o;
   endfunction

   // Byte (r,c) sits at bits [127-8*(r+4c) -: 8]; row r rotates left by r.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      return o;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] round_mid(input logic [127:0] s, input logic last);
      return last ? shift_rows(s) : mix_columns(shift_rows(s));
   endfunction

   logic             vld_p1, last_p1, rdy_p1, down_rdy;
   logic [127:0]     st_p1, key_p1, mid_p1;
   logic [TAG_W-1:0] tag_p1;

   assign rdy_p1   = !vld_p1 || down_rdy;
   assign in_ready = rdy_p1;

   // Stage 1: registered SubBytes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         st_p1   <= '0;
         key_p1  <= '0;
         last_p1 <= 1'b0;
         tag_p1  <= '0;
      end else if (rdy_p1) begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            st_p1   <= sub_bytes(in_data);
            key_p1  <= in_rkey;
            last_p1 <= in_last;
            tag_p1  <= in_tag;
         end
      end
   end

   assign mid_p1 = round_mid(st_p1, last_p1);

   if (TAG_W < 1) begin : g_bad_tag
      $error("aes_round_pipe: TAG_W must be at least 1");
   end

   if (PIPE_STAGES == 1) begin : g_one
      assign down_rdy  = out_ready;
      assign out_valid = vld_p1;
      assign out_data  = mid_p1 ^ key_p1;
      assign out_tag   = tag_p1;
   end else if (PIPE_STAGES == 2 || PIPE_STAGES == 3) begin : g_multi
      logic             vld_p2, rdy_p2, down_rdy2;
      logic [127:0]     st_p2, key_p2, ark_p2;
      logic [TAG_W-1:0] tag_p2;

      assign rdy_p2   = !vld_p2 || down_rdy2;
      assign down_rdy = rdy_p2;

      // Stage 2: registered ShiftRows/MixColumns, key still pending
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_p2 <= 1'b0;
            st_p2  <= '0;
            key_p2 <= '0;
            tag_p2 <= '0;
         end else if (rdy_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
               st_p2  <= mid_p1;
               key_p2 <= key_p1;
               tag_p2 <= tag_p1;
            end
         end
      end

      assign ark_p2 = st_p2 ^ key_p2;

      if (PIPE_STAGES == 2) begin : g_two
         assign down_rdy2 = out_ready;
         assign out_valid = vld_p2;
         assign out_data  = ark_p2;
         assign out_tag   = tag_p2;
      end else begin : g_three
         logic             vld_p3;
         logic [127:0]     st_p3;
         logic [TAG_W-1:0] tag_p3;

         assign down_rdy2 = !vld_p3 || out_ready;

         // Stage 3: registered AddRoundKey result drives the outputs
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_p3 <= 1'b0;
               st_p3  <= '0;
               tag_p3 <= '0;
            end else if (down_rdy2) begin
               vld_p3 <= vld_p2;
               if (vld_p2) begin
                  st_p3  <= ark_p2;
                  tag_p3 <= tag_p2;
               end
            end
         end

         assign out_valid = vld_p3;
         assign out_data  = st_p3;
         assign out_tag   = tag_p3;
      end
   end else begin : g_bad_stages
      $error("aes_round_pipe: PIPE_STAGES must be 1, 2 or 3");
      assign down_rdy  = 1'b0;
      assign out_valid = 1'b0;
      assign out_data  = '0;
      assign out_tag   = '0;
   end

endmodule
